// File: rtl/multiset_buf_ctrl.sv
// N-set rotating buffer: exec side fills its owned set, drain side reads committed sets in FIFO order.
// Set ownership is tracked by wr/rd pointers and an occupancy count driven by done handshakes.
module multiset_buf_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SETS   = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            exec_rdy,
    output logic [$clog2(NUM_SETS)-1:0]     exec_set,
    input  logic                            exec_done,
    input  logic                            exec_wr_en,
    input  logic                            exec_rd_en,
    input  logic [ADDR_WIDTH-1:0]           exec_addr,
    input  logic [DATA_WIDTH-1:0]           exec_wr_data,
    output logic [DATA_WIDTH-1:0]           exec_rd_data,
    output logic                            exec_rd_valid,
    output logic                            drain_rdy,
    output logic [$clog2(NUM_SETS)-1:0]     drain_set,
    input  logic                            drain_done,
    input  logic                            drain_rd_en,
    input  logic [ADDR_WIDTH-1:0]           drain_addr,
    output logic [DATA_WIDTH-1:0]           drain_rd_data,
    output logic                            drain_rd_valid,
    output logic [$clog2(NUM_SETS+1)-1:0]   occupancy,
    output logic                            err
);

    localparam int SET_W     = $clog2(NUM_SETS);
    localparam int OCC_W     = $clog2(NUM_SETS + 1);
    localparam int PHYS_W    = SET_W + ADDR_WIDTH;
    localparam int MEM_DEPTH = NUM_SETS << ADDR_WIDTH;

    logic [SET_W-1:0]      wr_ptr;
    logic [SET_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [PHYS_W-1:0]     exec_phys;
    logic [PHYS_W-1:0]     drain_phys;
    logic                  exec_done_ok;
    logic                  drain_done_ok;
    logic                  exec_wr_ok;
    logic                  exec_rd_go;
    logic                  proto_err;

    logic [DATA_WIDTH-1:0] exec_dat_p  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] drain_dat_p [RD_LATENCY];
    logic [RD_LATENCY-1:0] exec_vld_p;
    logic [RD_LATENCY-1:0] drain_vld_p;

    // Pointers wrap at NUM_SETS, which need not be a power of two.
    function automatic logic [SET_W-1:0] ptr_next(input logic [SET_W-1:0] p);
        if (p == SET_W'(NUM_SETS - 1)) begin
            return '0;
        end
        return p + SET_W'(1);
    endfunction

    assign exec_set   = wr_ptr;
    assign drain_set  = rd_ptr;
    assign exec_rdy   = (occupancy < OCC_W'(NUM_SETS));
    assign drain_rdy  = (occupancy != '0);

    assign exec_phys  = {wr_ptr, exec_addr};
    assign drain_phys = {rd_ptr, drain_addr};

    assign exec_done_ok  = exec_done & exec_rdy;
    assign drain_done_ok = drain_done & drain_rdy;
    assign exec_wr_ok    = exec_wr_en & exec_rdy;
    // A read issued together with a write is dropped (no-change mode).
    assign exec_rd_go    = exec_rd_en & ~exec_wr_en;
    assign proto_err     = (exec_done & ~exec_rdy) | (drain_done & ~drain_rdy) |
                           (exec_wr_en & ~exec_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            err       <= 1'b0;
        end else begin
            if (exec_done_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (drain_done_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({exec_done_ok, drain_done_ok})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (exec_wr_ok) begin
            mem[exec_phys] <= exec_wr_data;
        end
    end

    // Stage p0 is the array read; later stages only shift, and each stage
    // captures only on an incoming valid so outputs hold between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_vld_p  <= '0;
            drain_vld_p <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                exec_dat_p[i]  <= '0;
                drain_dat_p[i] <= '0;
            end
        end else begin
            exec_vld_p[0]  <= exec_rd_go;
            drain_vld_p[0] <= drain_rd_en;
            if (exec_rd_go) begin
                exec_dat_p[0] <= mem[exec_phys];
            end
            if (drain_rd_en) begin
                drain_dat_p[0] <= mem[drain_phys];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                exec_vld_p[i]  <= exec_vld_p[i-1];
                drain_vld_p[i] <= drain_vld_p[i-1];
                if (exec_vld_p[i-1]) begin
                    exec_dat_p[i] <= exec_dat_p[i-1];
                end
                if (drain_vld_p[i-1]) begin
                    drain_dat_p[i] <= drain_dat_p[i-1];
                end
            end
        end
    end

    assign exec_rd_data   = exec_dat_p[RD_LATENCY-1];
    assign exec_rd_valid  = exec_vld_p[RD_LATENCY-1];
    assign drain_rd_data  = drain_dat_p[RD_LATENCY-1];
    assign drain_rd_valid = drain_vld_p[RD_LATENCY-1];

endmodule

// File: tb/tb_multiset_buf_ctrl.sv
// Bench for multiset_buf_ctrl: two instances (2 sets / latency 1, 3 sets / latency 3) share
// one stimulus stream and are each compared every cycle against a set-level reference model.
module tb_multiset_buf_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        exec_done, exec_wr_en, exec_rd_en, drain_done, drain_rd_en;
    logic [8:0]  exec_addr, drain_addr;
    logic [15:0] exec_wr_data;

    logic        a_exec_rdy, a_drain_rdy, a_exec_rd_valid, a_drain_rd_valid, a_err;
    logic [0:0]  a_exec_set, a_drain_set;
    logic [1:0]  a_occ;
    logic [15:0] a_exec_rd_data, a_drain_rd_data;

    logic        b_exec_rdy, b_drain_rdy, b_exec_rd_valid, b_drain_rd_valid, b_err;
    logic [1:0]  b_exec_set, b_drain_set;
    logic [1:0]  b_occ;
    logic [15:0] b_exec_rd_data, b_drain_rd_data;

    multiset_buf_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .NUM_SETS(2), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst(rst),
        .exec_rdy(a_exec_rdy), .exec_set(a_exec_set), .exec_done(exec_done),
        .exec_wr_en(exec_wr_en), .exec_rd_en(exec_rd_en), .exec_addr(exec_addr),
        .exec_wr_data(exec_wr_data), .exec_rd_data(a_exec_rd_data), .exec_rd_valid(a_exec_rd_valid),
        .drain_rdy(a_drain_rdy), .drain_set(a_drain_set), .drain_done(drain_done),
        .drain_rd_en(drain_rd_en), .drain_addr(drain_addr),
        .drain_rd_data(a_drain_rd_data), .drain_rd_valid(a_drain_rd_valid),
        .occupancy(a_occ), .err(a_err)
    );

    multiset_buf_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_SETS(3), .RD_LATENCY(3)) u_b (
        .clk(clk), .rst(rst),
        .exec_rdy(b_exec_rdy), .exec_set(b_exec_set), .exec_done(exec_done),
        .exec_wr_en(exec_wr_en), .exec_rd_en(exec_rd_en), .exec_addr(exec_addr[3:0]),
        .exec_wr_data(exec_wr_data), .exec_rd_data(b_exec_rd_data), .exec_rd_valid(b_exec_rd_valid),
        .drain_rdy(b_drain_rdy), .drain_set(b_drain_set), .drain_done(drain_done),
        .drain_rd_en(drain_rd_en), .drain_addr(drain_addr[3:0]),
        .drain_rd_data(b_drain_rd_data), .drain_rd_valid(b_drain_rd_valid),
        .occupancy(b_occ), .err(b_err)
    );

    typedef struct {
        int          k;
        int          port;
        int          due;
        logic [15:0] d;
        bit          known;
    } pend_t;

    pend_t       pq[$];
    int          m_wr[2], m_rd[2], m_occ[2];
    bit          m_err[2];
    logic [15:0] m_mem[2][48];
    bit          m_known[2][48];
    bit          x_evld[2], x_dvld[2], x_eknown[2], x_dknown[2];
    logic [15:0] x_edat[2], x_ddat[2];

    int edge_n = 0;
    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int ns_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int rl_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = 0; m_rd[k] = 0; m_occ[k] = 0; m_err[k] = 1'b0;
            x_evld[k] = 1'b0; x_dvld[k] = 1'b0;
            x_edat[k] = '0; x_ddat[k] = '0;
            x_eknown[k] = 1'b1; x_dknown[k] = 1'b1;
        end
        pq.delete();
    endtask

    // One clock edge of the reference: ownership, errors, reads queued, then the write.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit    re, rd, collide;
            int    ei, di;
            pend_t p;
            re = (m_occ[k] < ns_of(k));
            rd = (m_occ[k] > 0);
            ei = m_wr[k] * 16 + int'(exec_addr);
            di = m_rd[k] * 16 + int'(drain_addr);
            if ((exec_done && !re) || (drain_done && !rd) || (exec_wr_en && !re)) m_err[k] = 1'b1;
            if (exec_rd_en && !exec_wr_en) begin
                p.k = k; p.port = 0; p.due = edge_n + rl_of(k) - 1;
                p.d = m_mem[k][ei]; p.known = re && m_known[k][ei];
                pq.push_back(p);
            end
            if (drain_rd_en) begin
                collide = exec_wr_en && re && (ei == di);
                p.k = k; p.port = 1; p.due = edge_n + rl_of(k) - 1;
                p.d = m_mem[k][di]; p.known = m_known[k][di] && !collide;
                pq.push_back(p);
            end
            if (exec_wr_en && re) begin
                m_mem[k][ei] = exec_wr_data;
                m_known[k][ei] = 1'b1;
            end
            if (exec_done && re) begin
                m_wr[k] = (m_wr[k] + 1) % ns_of(k);
                m_occ[k]++;
            end
            if (drain_done && rd) begin
                m_rd[k] = (m_rd[k] + 1) % ns_of(k);
                m_occ[k]--;
            end
        end
    endtask

    task automatic retire();
        pend_t keep[$];
        for (int k = 0; k < 2; k++) begin
            x_evld[k] = 1'b0;
            x_dvld[k] = 1'b0;
        end
        foreach (pq[i]) begin
            if (pq[i].due == edge_n) begin
                if (pq[i].port == 0) begin
                    x_evld[pq[i].k] = 1'b1; x_edat[pq[i].k] = pq[i].d; x_eknown[pq[i].k] = pq[i].known;
                end else begin
                    x_dvld[pq[i].k] = 1'b1; x_ddat[pq[i].k] = pq[i].d; x_dknown[pq[i].k] = pq[i].known;
                end
            end else begin
                keep.push_back(pq[i]);
            end
        end
        pq = keep;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic        o_erdy, o_drdy, o_err, o_ev, o_dv;
            logic [1:0]  o_es, o_ds, o_occ;
            logic [15:0] o_ed, o_dd;
            if (k == 0) begin
                o_erdy = a_exec_rdy; o_drdy = a_drain_rdy; o_err = a_err;
                o_ev = a_exec_rd_valid; o_dv = a_drain_rd_valid;
                o_es = {1'b0, a_exec_set}; o_ds = {1'b0, a_drain_set}; o_occ = a_occ;
                o_ed = a_exec_rd_data; o_dd = a_drain_rd_data;
            end else begin
                o_erdy = b_exec_rdy; o_drdy = b_drain_rdy; o_err = b_err;
                o_ev = b_exec_rd_valid; o_dv = b_drain_rd_valid;
                o_es = b_exec_set; o_ds = b_drain_set; o_occ = b_occ;
                o_ed = b_exec_rd_data; o_dd = b_drain_rd_data;
            end
            chk($sformatf("k%0d exec_rdy", k), o_erdy, m_occ[k] < ns_of(k));
            chk($sformatf("k%0d drain_rdy", k), o_drdy, m_occ[k] > 0);
            chk($sformatf("k%0d exec_set", k), o_es, m_wr[k]);
            chk($sformatf("k%0d drain_set", k), o_ds, m_rd[k]);
            chk($sformatf("k%0d occupancy", k), o_occ, m_occ[k]);
            chk($sformatf("k%0d err", k), o_err, m_err[k]);
            chk($sformatf("k%0d exec_rd_valid", k), o_ev, x_evld[k]);
            chk($sformatf("k%0d drain_rd_valid", k), o_dv, x_dvld[k]);
            if (x_eknown[k]) chk($sformatf("k%0d exec_rd_data", k), o_ed, x_edat[k]);
            if (x_dknown[k]) chk($sformatf("k%0d drain_rd_data", k), o_dd, x_ddat[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!rst) model_edge();
        retire();
        #1;
        check_all();
        n_vec++;
    endtask

    // Asserted away from the clock edge to show the asynchronous clear.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        exec_done = 0; exec_wr_en = 0; exec_rd_en = 0; drain_done = 0; drain_rd_en = 0;
        exec_addr = '0; drain_addr = '0; exec_wr_data = '0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 48; i++) m_known[k][i] = 1'b0;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #3;
        check_all();
        chk("t1 exec_rdy", a_exec_rdy, 1'b1);
        chk("t1 occupancy", a_occ, 2'd0);
        tick();
        rst = 1'b0;
        tick();

        // Ping-pong: write one word, commit, drain it back.
        exec_wr_en = 1; exec_addr = 9'd5; exec_wr_data = 16'hA5A5;
        tick();
        exec_wr_en = 0; exec_done = 1;
        tick();
        exec_done = 0;
        chk("t2 exec_set", a_exec_set, 1'b1);
        chk("t2 drain_set", a_drain_set, 1'b0);
        chk("t2 occupancy", a_occ, 2'd1);
        drain_rd_en = 1; drain_addr = 9'd5;
        tick();
        drain_rd_en = 0;
        chk("t2 drain_rd_valid", a_drain_rd_valid, 1'b1);
        chk("t2 drain_rd_data", a_drain_rd_data, 16'hA5A5);
        tick();

        // Fill the three-set instance and try a blocked write.
        exec_done = 1;
        tick();
        tick();
        exec_done = 0;
        chk("t3 occupancy", b_occ, 2'd3);
        chk("t3 exec_rdy", b_exec_rdy, 1'b0);
        exec_wr_en = 1; exec_addr = 9'd5; exec_wr_data = 16'h1234;
        tick();
        exec_wr_en = 0;
        chk("t3 err", b_err, 1'b1);
        drain_rd_en = 1; drain_addr = 9'd5;
        tick();
        drain_rd_en = 0;
        tick();
        tick();
        chk("t3 drain_rd_valid", b_drain_rd_valid, 1'b1);
        chk("t3 mem unchanged", b_drain_rd_data, 16'hA5A5);
        drain_done = 1;
        tick();
        drain_done = 0;
        chk("t3 exec_rdy after drain", b_exec_rdy, 1'b1);
        chk("t3 exec_set wrap", b_exec_set, 2'd0);

        // Reset with reads in flight at occupancy 2.
        exec_rd_en = 1; exec_addr = 9'd5;
        tick();
        tick();
        tick();
        exec_rd_en = 0;
        chk("t6 valid before rst", b_exec_rd_valid, 1'b1);
        chk("t6 occupancy before rst", b_occ, 2'd2);
        do_reset();
        chk("t6 exec_rd_valid", b_exec_rd_valid, 1'b0);
        chk("t6 err", b_err, 1'b0);
        chk("t6 drain_set", b_drain_set, 2'd0);

        // Simultaneous commit and release at occupancy 1.
        exec_done = 1;
        tick();
        drain_done = 1;
        tick();
        exec_done = 0; drain_done = 0;
        chk("t4 occupancy", b_occ, 2'd1);
        chk("t4 exec_set", b_exec_set, 2'd2);
        chk("t4 drain_set", b_drain_set, 2'd1);
        chk("t4 a exec_set wrap", a_exec_set, 1'b0);

        // Latency-3 back-to-back reads, then a dropped read under a write.
        for (int i = 0; i < 4; i++) begin
            exec_wr_en = 1; exec_addr = 9'(i); exec_wr_data = 16'(16'h10 + i);
            tick();
        end
        exec_wr_en = 0;
        for (int i = 0; i < 4; i++) begin
            exec_rd_en = 1; exec_addr = 9'(i);
            tick();
            chk("t5 valid", b_exec_rd_valid, i >= 2);
            if (i >= 2) chk("t5 data", b_exec_rd_data, 16'(16'h10 + i - 2));
        end
        exec_rd_en = 0;
        tick();
        chk("t5 data2", b_exec_rd_data, 16'h12);
        tick();
        chk("t5 data3", b_exec_rd_data, 16'h13);
        tick();
        chk("t5 valid end", b_exec_rd_valid, 1'b0);
        chk("t5 hold", b_exec_rd_data, 16'h13);
        exec_wr_en = 1; exec_rd_en = 1; exec_addr = 9'd6; exec_wr_data = 16'h0066;
        tick();
        exec_wr_en = 0; exec_rd_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5 dropped read", b_exec_rd_valid, 1'b0);
        end
        chk("t5 no err", b_err, 1'b0);

        // Unconstrained random traffic, protocol errors included.
        for (int i = 0; i < 150; i++) begin
            exec_done    = ($urandom_range(0, 5) == 0);
            drain_done   = ($urandom_range(0, 5) == 0);
            exec_wr_en   = $urandom_range(0, 1);
            exec_rd_en   = $urandom_range(0, 1);
            drain_rd_en  = $urandom_range(0, 1);
            exec_addr    = 9'($urandom_range(0, 15));
            drain_addr   = 9'($urandom_range(0, 15));
            exec_wr_data = 16'($urandom);
            tick();
        end
        idle_inputs();
        do_reset();

        // Protocol-respecting random traffic.
        for (int i = 0; i < 300; i++) begin
            bit ok_e, ok_d;
            ok_e = (m_occ[0] < 2) && (m_occ[1] < 3);
            ok_d = (m_occ[0] > 0) && (m_occ[1] > 0);
            exec_done    = ok_e && ($urandom_range(0, 7) == 0);
            drain_done   = ok_d && ($urandom_range(0, 7) == 0);
            exec_wr_en   = ok_e && ($urandom_range(0, 1) == 1);
            exec_rd_en   = $urandom_range(0, 1);
            drain_rd_en  = $urandom_range(0, 1);
            exec_addr    = 9'($urandom_range(0, 15));
            drain_addr   = 9'($urandom_range(0, 15));
            exec_wr_data = 16'($urandom);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
